field_match_scan: RTL and testbench

Pipelined, stream-oriented successor of the nibble compare unit in the processor datapath. Each accepted word is split into `FIELD_W`-bit fields; every field is masked and compared against a pattern (optionally inverted), yielding a per-field match mask, zero flag, match count and lowest matching field index. Across a multi-word burst it accumulates a saturating total match count and the index of the first word containing a match. It sits behind a valid/ready stream, e.g. a string or vector scan engine, and supports backpressure.

---
 rtl/field_match_scan.sv | 177 +++++++++++++++++
 tb/tb_field_match_scan.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_match_scan.sv
// Two-stage valid/ready field scanner: splits each word into FIELD_W-bit fields, masks and
// compares them, then reports per-beat match statistics plus burst-wide accumulators.
module field_match_scan #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FIELD_W = 4,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned NF     = WIDTH / FIELD_W,
  localparam int unsigned CW     = $clog2(NF + 1),
  localparam int unsigned IW     = $clog2(NF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  input  logic [FIELD_W-1:0] pattern,
  input  logic [FIELD_W-1:0] mask,
  input  logic               invert,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NF-1:0]      out_mask,
  output logic               out_zero,
  output logic [CW-1:0]      out_count,
  output logic [IW-1:0]      out_first,
  output logic               out_last,
  output logic [CNT_W-1:0]   acc_count,
  output logic [CNT_W-1:0]   acc_word,
  output logic               acc_hit
);

  logic en;

  // Stage S1 state
  logic          s1_valid_q, s1_valid_d;
  logic [NF-1:0] s1_match_q, s1_match_d;
  logic          s1_last_q, s1_last_d;

  // Stage S2 / output state
  logic             out_valid_q, out_valid_d;
  logic [NF-1:0]    out_mask_q, out_mask_d;
  logic             out_zero_q, out_zero_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic [IW-1:0]    out_first_q, out_first_d;
  logic             out_last_q, out_last_d;

  // Burst state
  logic             start_q, start_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] acc_count_q, acc_count_d;
  logic [CNT_W-1:0] acc_word_q, acc_word_d;
  logic             acc_hit_q, acc_hit_d;

  logic [NF-1:0]    match_vec;
  logic [CW-1:0]    pop;
  logic [IW-1:0]    first_idx;
  logic [CNT_W:0]   acc_sum;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < int'(NF); i++) begin
      match_vec[i] = ((in_data[i*FIELD_W +: FIELD_W] & mask) == pattern) ^ invert;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_match_d = s1_match_q;
    s1_last_d  = s1_last_q;
    if (en) begin
      s1_valid_d = in_valid;
      s1_match_d = match_vec;
      s1_last_d  = in_last;
    end
  end

  // Popcount and LSB-first priority encode of the S1 match vector.
  always_comb begin
    pop       = '0;
    first_idx = '0;
    for (int i = 0; i < int'(NF); i++) begin
      pop = pop + CW'(s1_match_q[i]);
    end
    for (int i = int'(NF) - 1; i >= 0; i--) begin
      if (s1_match_q[i]) first_idx = IW'(i);
    end
  end

  assign acc_sum = {1'b0, acc_count_q} + (CNT_W + 1)'(pop);

  always_comb begin
    out_valid_d = out_valid_q;
    out_mask_d  = out_mask_q;
    out_zero_d  = out_zero_q;
    out_count_d = out_count_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    start_d     = start_q;
    beat_d      = beat_q;
    acc_count_d = acc_count_q;
    acc_word_d  = acc_word_q;
    acc_hit_d   = acc_hit_q;
    if (en) begin
      out_valid_d = s1_valid_q;
      // Bubbles only drop out_valid; everything else keeps the last beat's values.
      if (s1_valid_q) begin
        out_mask_d  = s1_match_q;
        out_zero_d  = (s1_match_q == '0);
        out_count_d = pop;
        out_first_d = first_idx;
        out_last_d  = s1_last_q;
        start_d     = s1_last_q;
        if (start_q) begin
          acc_count_d = CNT_W'(pop);
          beat_d      = '0;
          acc_hit_d   = (s1_match_q != '0);
          acc_word_d  = '0;
        end else begin
          acc_count_d = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
          beat_d      = (beat_q == '1) ? beat_q : beat_q + CNT_W'(1);
          if (!acc_hit_q && (s1_match_q != '0)) begin
            acc_hit_d  = 1'b1;
            acc_word_d = beat_d;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_match_q  <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_zero_q  <= 1'b0;
      out_count_q <= '0;
      out_first_q <= '0;
      out_last_q  <= 1'b0;
      start_q     <= 1'b1;
      beat_q      <= '0;
      acc_count_q <= '0;
      acc_word_q  <= '0;
      acc_hit_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_match_q  <= s1_match_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_zero_q  <= out_zero_d;
      out_count_q <= out_count_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      start_q     <= start_d;
      beat_q      <= beat_d;
      acc_count_q <= acc_count_d;
      acc_word_q  <= acc_word_d;
      acc_hit_q   <= acc_hit_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mask  = out_mask_q;
  assign out_zero  = out_zero_q;
  assign out_count = out_count_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign acc_count = acc_count_q;
  assign acc_word  = acc_word_q;
  assign acc_hit   = acc_hit_q;

endmodule

// File: tb/tb_field_match_scan.sv
// Bench for field_match_scan: directed beats, a beat-ordered reference model with a per-cycle
// compare process, and literal checks; a CNT_W=4 instance shares the stimulus for saturation.
module tb_field_match_scan;

  localparam int NF = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [3:0]  pattern = 4'hA;
  logic [3:0]  mask = 4'hF;
  logic        invert = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_zero, out_last, acc_hit;
  logic [7:0]  out_mask;
  logic [3:0]  out_count;
  logic [2:0]  out_first;
  logic [15:0] acc_count, acc_word;

  logic        s_in_ready, s_out_valid, s_out_zero, s_out_last, s_acc_hit;
  logic [7:0]  s_out_mask;
  logic [3:0]  s_out_count;
  logic [2:0]  s_out_first;
  logic [3:0]  s_acc_count, s_acc_word;

  int vectors = 0;
  int miscompares = 0;
  int n_out = 0;

  always #5 clk = ~clk;

  field_match_scan #(.WIDTH(32), .FIELD_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .pattern(pattern), .mask(mask), .invert(invert),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_zero(out_zero),
    .out_count(out_count), .out_first(out_first), .out_last(out_last),
    .acc_count(acc_count), .acc_word(acc_word), .acc_hit(acc_hit)
  );

  field_match_scan #(.WIDTH(32), .FIELD_W(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_last(in_last), .pattern(pattern), .mask(mask), .invert(invert),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_mask(s_out_mask),
    .out_zero(s_out_zero), .out_count(s_out_count), .out_first(s_out_first),
    .out_last(s_out_last), .acc_count(s_acc_count), .acc_word(s_acc_word),
    .acc_hit(s_acc_hit)
  );

  typedef struct packed {
    logic [7:0]  mask;
    logic        zero;
    logic [3:0]  count;
    logic [2:0]  first;
    logic        last;
    logic [15:0] acc;
    logic [15:0] word;
    logic        hit;
    logic [3:0]  acc_s;
    logic [3:0]  word_s;
  } exp_t;

  exp_t q[$];
  bit   m_start = 1'b1;
  int   m_acc = 0, m_acc_s = 0, m_idx = 0, m_word = 0;
  bit   m_hit = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: one call per accepted beat, in acceptance order.
  task automatic model_accept(input logic [31:0] d, input logic [3:0] pat,
                              input logic [3:0] msk, input logic inv, input logic last);
    exp_t e;
    logic [7:0] mk;
    int cnt, fst;
    bit found;
    mk = '0;
    for (int i = 0; i < NF; i++) mk[i] = ((d[i*4 +: 4] & msk) == pat) ^ inv;
    cnt = $countones(mk);
    fst = 0;
    found = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (mk[i] && !found) begin
        fst = i;
        found = 1'b1;
      end
    end
    if (m_start) begin
      m_acc = cnt; m_acc_s = cnt; m_idx = 0; m_hit = 1'b0; m_word = 0;
    end else begin
      m_acc   = (m_acc + cnt > 65535) ? 65535 : m_acc + cnt;
      m_acc_s = (m_acc_s + cnt > 15) ? 15 : m_acc_s + cnt;
      m_idx   = (m_idx + 1 > 65535) ? 65535 : m_idx + 1;
    end
    if (!m_hit && mk != 0) begin
      m_hit = 1'b1;
      m_word = m_idx;
    end
    m_start = last;
    e.mask = mk; e.zero = (mk == 0); e.count = 4'(cnt); e.first = 3'(fst); e.last = last;
    e.acc = 16'(m_acc); e.word = 16'(m_word); e.hit = m_hit;
    e.acc_s = 4'(m_acc_s); e.word_s = (m_word > 15) ? 4'd15 : 4'(m_word);
    q.push_back(e);
  endtask

  // Compare process: 1 ns before each rising edge, when inputs and outputs are settled.
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (reset) begin
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      q.delete();
      m_start = 1'b1; m_acc = 0; m_acc_s = 0; m_idx = 0; m_hit = 1'b0; m_word = 0;
    end else begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, !out_valid || out_ready});
      chk("sat_out_valid", {31'b0, s_out_valid}, {31'b0, out_valid});
      if (out_valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_out: out_valid=1, expected no pending result (t=%0t)", $time);
        end else begin
          e = q[0];
          chk("out_mask", {24'b0, out_mask}, {24'b0, e.mask});
          chk("out_zero", {31'b0, out_zero}, {31'b0, e.zero});
          chk("out_count", {28'b0, out_count}, {28'b0, e.count});
          chk("out_first", {29'b0, out_first}, {29'b0, e.first});
          chk("out_last", {31'b0, out_last}, {31'b0, e.last});
          chk("acc_count", {16'b0, acc_count}, {16'b0, e.acc});
          chk("acc_word", {16'b0, acc_word}, {16'b0, e.word});
          chk("acc_hit", {31'b0, acc_hit}, {31'b0, e.hit});
          chk("sat_acc_count", {28'b0, s_acc_count}, {28'b0, e.acc_s});
          chk("sat_acc_word", {28'b0, s_acc_word}, {28'b0, e.word_s});
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) model_accept(in_data, pattern, mask, invert, in_last);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] pat, input logic [3:0] msk,
                      input logic inv, input logic last);
    in_valid = 1'b1; in_data = d; pattern = pat; mask = msk; invert = inv; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: out_valid=0, expected 1 within 10 cycles", name);
    end
  endtask

  task automatic wait_last(input string name);
    int n;
    n = 0;
    while (!(out_valid && out_last) && n < 12) begin
      tick();
      n++;
    end
    if (!(out_valid && out_last)) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no out_last beat, expected one within 12 cycles", name);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  logic [31:0] bp [4];
  logic        ir;
  int          k, n0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bp[0] = 32'h0000_000A; bp[1] = 32'hA0A0_A0A0; bp[2] = 32'hAA00_0000; bp[3] = 32'h0000_AAAA;
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_acc_count", {16'b0, acc_count}, 32'd0);
    chk("rst_out_mask", {24'b0, out_mask}, 32'd0);
    reset = 1'b0;
    tick();

    // Single beat: S1 at the accept edge, visible after the following edge.
    send(32'h00A0_A00A, 4'hA, 4'hF, 1'b0, 1'b1);
    chk("single_lat_early", {31'b0, out_valid}, 32'd0);
    tick();
    chk("single_out_valid", {31'b0, out_valid}, 32'd1);
    chk("single_mask", {24'b0, out_mask}, 32'h29);
    chk("single_count", {28'b0, out_count}, 32'd3);
    chk("single_first", {29'b0, out_first}, 32'd0);
    chk("single_zero", {31'b0, out_zero}, 32'd0);
    chk("single_acc_count", {16'b0, acc_count}, 32'd3);
    chk("single_acc_word", {16'b0, acc_word}, 32'd0);
    chk("single_acc_hit", {31'b0, acc_hit}, 32'd1);
    tick();

    // Invert and mask
    send(32'h0, 4'h0, 4'hF, 1'b1, 1'b1);
    wait_out("inv0");
    chk("inv0_mask", {24'b0, out_mask}, 32'h00);
    chk("inv0_zero", {31'b0, out_zero}, 32'd1);
    chk("inv0_first", {29'b0, out_first}, 32'd0);
    tick();
    send(32'h0, 4'h1, 4'hE, 1'b0, 1'b1);
    wait_out("mskE");
    chk("mskE_mask", {24'b0, out_mask}, 32'h00);
    tick();
    send(32'h0, 4'h1, 4'hE, 1'b1, 1'b1);
    wait_out("mskE_inv");
    chk("mskE_inv_mask", {24'b0, out_mask}, 32'hFF);
    chk("mskE_inv_count", {28'b0, out_count}, 32'd8);
    tick();

    // Burst accumulation, back to back
    pattern = 4'hA; mask = 4'hF; invert = 1'b0;
    in_valid = 1'b1; in_data = 32'h0; in_last = 1'b0; tick();
    in_data = 32'hAAAA_AAAA; tick();
    in_data = 32'h0000_000A; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    wait_last("burst");
    chk("burst_count", {28'b0, out_count}, 32'd1);
    chk("burst_acc_count", {16'b0, acc_count}, 32'd9);
    chk("burst_acc_word", {16'b0, acc_word}, 32'd1);
    chk("burst_acc_hit", {31'b0, acc_hit}, 32'd1);
    send(32'h0000_000A, 4'hA, 4'hF, 1'b0, 1'b1);
    wait_out("restart");
    chk("restart_acc_count", {16'b0, acc_count}, 32'd1);
    chk("restart_acc_word", {16'b0, acc_word}, 32'd0);
    tick();

    // Saturation on the CNT_W=4 instance
    in_valid = 1'b1; in_data = 32'hAAAA_AAAA; in_last = 1'b0; tick();
    in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    wait_out("sat");
    chk("sat_first_acc", {28'b0, s_acc_count}, 32'd8);
    tick();
    chk("sat_second_valid", {31'b0, s_out_valid}, 32'd1);
    chk("sat_second_acc", {28'b0, s_acc_count}, 32'd15);
    chk("wide_second_acc", {16'b0, acc_count}, 32'd16);
    tick();
    drain();

    // Backpressure
    out_ready = 1'b0;
    tick();
    n0 = n_out;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = bp[k]; in_last = (k == 3);
      ir = in_ready;
      tick();
      if (ir) k++;
    end
    chk("bp_accepts", k, 2);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    tick(); tick();
    chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_hold_mask", {24'b0, out_mask}, 32'h01);
    out_ready = 1'b1;
    while (k < 4) begin
      in_valid = 1'b1; in_data = bp[k]; in_last = (k == 3);
      tick();
      k++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_last("bp");
    chk("bp_last_acc", {16'b0, acc_count}, 32'd11);
    drain();
    chk("bp_results", n_out - n0, 4);

    // Reset mid-burst, asserted between edges
    in_valid = 1'b1; in_data = 32'hAAAA_AAAA; in_last = 1'b0; tick();
    tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_mask", {24'b0, out_mask}, 32'd0);
    chk("mid_rst_count", {28'b0, out_count}, 32'd0);
    chk("mid_rst_acc_count", {16'b0, acc_count}, 32'd0);
    chk("mid_rst_acc_hit", {31'b0, acc_hit}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    send(32'h0000_00A0, 4'hA, 4'hF, 1'b0, 1'b1);
    wait_out("post_rst");
    chk("post_rst_mask", {24'b0, out_mask}, 32'h02);
    chk("post_rst_first", {29'b0, out_first}, 32'd1);
    chk("post_rst_acc_count", {16'b0, acc_count}, 32'd1);
    chk("post_rst_acc_word", {16'b0, acc_word}, 32'd0);
    tick();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
